uart: RTL and testbench
=======================

Name: uart

Overview:
- 8N1 UART echo block: receives serial bytes on rxd and retransmits each received byte on txd.
- Contains its own baud-tick generator, sub-module baud_rate_generation, which runs at 16x oversampling.
- Sits between a board pin pair and the 100 MHz system clock domain.
- Serves as a standalone loopback/echo peripheral.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, baud ticks per bit.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) rounded to nearest = 651, sysclk cycles per baud tick.

Ports:
- sysclk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-high reset.
- rxd  input  1  serial receive line, idles high.
- txd  output  1  serial transmit line, idles high.

Behaviour:
- Clocking and reset:
  - One clock (sysclk). Reset is synchronous and active-high.
  - While reset=1, all state returns to idle on each sysclk edge: txd=1, counters=0, buffers empty.
  - Reset mid-frame aborts both RX and TX. txd goes high on the next edge.
- baud_rate_generation:
  - Counter 0..DIV-1 that wraps.
  - Output baud is a one-sysclk-wide high pulse when the counter wraps; reset value 0.
  - Nominal tick period 651 cycles = 6.51 us; 16 ticks = 104.16 us per bit.
- rxd synchronisation: rxd passes through a 2-flop synchroniser before use.
- RX state machine (IDLE, START, DATA, STOP), advancing only on baud ticks:
  - IDLE: a synced rxd=0 seen on a tick enters START with tick count 0.
  - START: at tick 7 (mid-bit), if rxd=1 it is a glitch and returns to IDLE; otherwise DATA.
  - DATA: samples every 16 ticks at mid-bit; 8 bits, LSB first, shifted into rx_shift.
  - STOP: samples mid-stop-bit.
    - Sample = 1: byte is valid; assert a one-cycle rx_done.
    - Sample = 0: framing error; byte discarded; wait for rxd=1 before IDLE.
  - Return to IDLE immediately after the stop sample, so the next start edge is caught.
- Echo path:
  - rx_done loads the byte into a one-entry holding register (hold_valid).
  - If hold_valid is already set, the new byte is dropped (overrun) and the old byte is kept.
  - TX takes the held byte when TX is idle and hold_valid=1; this clears hold_valid in the same cycle.
- TX state machine (IDLE, START, DATA, STOP):
  - Each bit lasts exactly 16 baud ticks.
  - Sends start=0, then 8 data bits LSB first, then stop=1.
  - Returns to IDLE after the 16th tick of the stop bit.
  - The transmission begins on the first baud tick after load.
  - txd is registered, with no combinational path from rxd.
- Latency: first txd falling edge occurs within 2 baud ticks after rx_done, i.e. about 9.5 bit times after the RX start edge.
- Back-to-back RX frames at the same baud rate never overrun: TX finishes each frame before the next rx_done.
- Internal counters:
  - 10-bit divider.
  - 4-bit tick counter per engine.
  - 3-bit bit index per engine; wraps are explicit.

Optional Feature:
- Macro UART_MAJORITY_VOTE_EN.
- Defined: every RX sample (start, data, stop) is the 2-of-3 majority of synced rxd captured at ticks 6, 7 and 8 of the bit. The decision is made at tick 8.
- Undefined: a single sample at tick 7.
- Frame timing and TX are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - CLK_FREQ, BAUD, OVERSAMPLE and DIV as localparams.
  - A shared state enum (IDLE, START, DATA, STOP) used by both engines.
  - The width constants.
- One sub-module, baud_rate_generation, with ports baud (output), sysclk and reset.
- RX, holding register and TX are coded inline in uart.

Test Plan:
- Reset held 2.4 ms with rxd=1 -> txd=1 throughout; baud pulses recur every 651 cycles after release.
- Single frame 0xE9 at 104166.667 ns/bit (rxd: 0,1,0,0,1,0,1,1,1,1) -> txd emits start, bits 1,0,0,1,0,1,1,1, stop; each bit 104.16 us ±1 tick.
- Two back-to-back 0xE9 frames -> two echoed 0xE9 frames, no drop, txd high between or after frames.
- 2.4 ms gap, then another 0xE9 -> a third 0xE9 echo; idle stays high.
- 3 us low glitch on rxd -> no RX start, txd stays 1.
- Frame with stop bit=0 -> no echo; the next valid frame 0x55 echoes 0x55.
- Reset asserted mid-TX -> txd=1 next edge; no residual frame after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, widths and the engine state type for the uart echo block.
// Build option: define UART_MAJORITY_VOTE_EN for 2-of-3 RX sampling at ticks 6/7/8.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 100000000;
  localparam int unsigned BAUD       = 9600;
  localparam int unsigned OVERSAMPLE = 16;
  // Rounded to nearest: 100e6 / 153600 = 651.04 -> 651
  localparam int unsigned DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

  localparam int unsigned DIV_W  = 10;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_if.sv
// Board pin pair of the uart echo block.
//   rxd : serial line into the block, idles high
//   txd : serial line out of the block, idles high
// master = the far end (drives rxd), slave = the uart block (drives txd).
interface uart_if;
  logic rxd;
  logic txd;

  modport master (output rxd, input txd);
  modport slave  (input rxd, output txd);
endinterface

// File: rtl/baud_rate_generation.sv
// Baud tick generator: one-sysclk-wide pulse every DIV_P cycles (16x bit rate).
//   sysclk : system clock
//   reset  : synchronous active-high reset
//   baud   : registered tick pulse, 0 in reset
module baud_rate_generation
  import uart_pkg::*;
#(
  parameter int unsigned DIV_P = DIV
) (
  input  logic sysclk,
  input  logic reset,
  output logic baud
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV_P - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             baud_q, baud_d;

  // Wrapping divider; the wrap itself is the tick
  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    baud_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      baud_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_q  <= '0;
      baud_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      baud_q <= baud_d;
    end
  end

  assign baud = baud_q;

endmodule

// File: rtl/uart.sv
// 8N1 UART echo: every byte received on pins.rxd is retransmitted on pins.txd.
//   sysclk : system clock
//   reset  : synchronous active-high reset (aborts RX and TX, txd high)
//   pins   : uart_if.slave (rxd in, txd out, registered)
// Build option: UART_MAJORITY_VOTE_EN selects 2-of-3 RX sampling (ticks 6,7,8,
// decision at 8); otherwise a single sample at tick 7.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned DIV_P = DIV
) (
  input  logic  sysclk,
  input  logic  reset,
  uart_if.slave pins
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  logic baud;

  baud_rate_generation #(.DIV_P(DIV_P)) u_baud (
    .sysclk (sysclk),
    .reset  (reset),
    .baud   (baud)
  );

  // ---------------------------------------------------------------- flops
  uart_state_e       rx_state_q, rx_state_d;
  uart_state_e       tx_state_q, tx_state_d;
  logic              rxd_meta_q, rxd_meta_d;
  logic              rxd_sync_q, rxd_sync_d;
  logic [TICK_W-1:0] rx_tick_q, rx_tick_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_byte_q, hold_byte_d;
  logic [TICK_W-1:0] tx_tick_q, tx_tick_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_pend_q, tx_pend_d;
  logic              txd_q, txd_d;

  logic              rx_sample_c;
  logic              rx_bit_c;
  logic              tx_take_c;

  // ---------------------------------------------------------------- RX sampling
`ifdef UART_MAJORITY_VOTE_EN
  localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(8);
  logic [1:0] vote_q, vote_d;

  // Capture ticks 6 and 7; tick 8 supplies the third vote live
  always_comb begin
    vote_d = vote_q;
    if (baud && rx_tick_q == TICK_W'(6)) vote_d[0] = rxd_sync_q;
    if (baud && rx_tick_q == TICK_W'(7)) vote_d[1] = rxd_sync_q;
  end

  always_ff @(posedge sysclk) begin
    if (reset) vote_q <= 2'b11;
    else       vote_q <= vote_d;
  end

  assign rx_bit_c = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_sync_q) |
                    (vote_q[1] & rxd_sync_q);
`else
  localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(7);
  assign rx_bit_c = rxd_sync_q;
`endif

  assign rx_sample_c = baud && (rx_tick_q == SAMPLE_TICK);
  assign tx_take_c   = (tx_state_q == IDLE) && !tx_pend_q && hold_valid_q;

  // ---------------------------------------------------------------- state registers
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_state_q <= IDLE;
      tx_state_q <= IDLE;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
    end
  end

  // ---------------------------------------------------------------- RX next state
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      IDLE:  if (baud && !rxd_sync_q) rx_state_d = START;
      START: begin
        if (rx_sample_c && rx_bit_c)              rx_state_d = IDLE;
        else if (baud && rx_tick_q == TICK_LAST)  rx_state_d = DATA;
      end
      DATA:  if (baud && rx_tick_q == TICK_LAST && rx_idx_q == IDX_LAST) rx_state_d = STOP;
      STOP: begin
        // After a framing error, hold off until the line is idle again
        if (rx_ferr_q) begin
          if (rxd_sync_q) rx_state_d = IDLE;
        end else if (rx_sample_c && rx_bit_c) begin
          rx_state_d = IDLE;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- TX next state
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      IDLE:  if (tx_pend_q && baud) tx_state_d = START;
      START: if (baud && tx_tick_q == TICK_LAST) tx_state_d = DATA;
      DATA:  if (baud && tx_tick_q == TICK_LAST && tx_idx_q == IDX_LAST) tx_state_d = STOP;
      STOP:  if (baud && tx_tick_q == TICK_LAST) tx_state_d = IDLE;
      default: tx_state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs / datapath
  always_comb begin
    rxd_meta_d   = pins.rxd;
    rxd_sync_d   = rxd_meta_q;
    rx_tick_d    = rx_tick_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_done_d    = 1'b0;
    rx_ferr_d    = rx_ferr_q;
    hold_valid_d = hold_valid_q;
    hold_byte_d  = hold_byte_q;
    tx_tick_d    = tx_tick_q;
    tx_idx_d     = tx_idx_q;
    tx_shift_d   = tx_shift_q;
    tx_pend_d    = tx_pend_q;
    txd_d        = txd_q;

    // RX: tick counter runs 0..15 per bit, bit index 0..7
    case (rx_state_q)
      IDLE: begin
        rx_tick_d = '0;
        rx_idx_d  = '0;
        rx_ferr_d = 1'b0;
      end
      START: begin
        if (baud) rx_tick_d = (rx_tick_q == TICK_LAST) ? '0 : rx_tick_q + TICK_W'(1);
      end
      DATA: begin
        if (baud) rx_tick_d = (rx_tick_q == TICK_LAST) ? '0 : rx_tick_q + TICK_W'(1);
        if (rx_sample_c) rx_shift_d = {rx_bit_c, rx_shift_q[DATA_W-1:1]};
        if (baud && rx_tick_q == TICK_LAST)
          rx_idx_d = (rx_idx_q == IDX_LAST) ? '0 : rx_idx_q + IDX_W'(1);
      end
      STOP: begin
        if (baud) rx_tick_d = (rx_tick_q == TICK_LAST) ? '0 : rx_tick_q + TICK_W'(1);
        if (!rx_ferr_q && rx_sample_c) begin
          if (rx_bit_c) rx_done_d = 1'b1;
          else          rx_ferr_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Holding register: TX drains it; a byte arriving while full is dropped
    if (tx_take_c) hold_valid_d = 1'b0;
    if (rx_done_q && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_byte_d  = rx_shift_q;
    end

    // TX: byte is parked in tx_shift until the next baud tick starts the frame
    case (tx_state_q)
      IDLE: begin
        tx_tick_d = '0;
        tx_idx_d  = '0;
        txd_d     = 1'b1;
        if (tx_take_c) begin
          tx_shift_d = hold_byte_q;
          tx_pend_d  = 1'b1;
        end
        if (tx_pend_q && baud) begin
          txd_d     = 1'b0;
          tx_pend_d = 1'b0;
        end
      end
      START: begin
        if (baud) begin
          tx_tick_d = (tx_tick_q == TICK_LAST) ? '0 : tx_tick_q + TICK_W'(1);
          if (tx_tick_q == TICK_LAST) txd_d = tx_shift_q[0];
        end
      end
      DATA: begin
        if (baud) begin
          tx_tick_d = (tx_tick_q == TICK_LAST) ? '0 : tx_tick_q + TICK_W'(1);
          if (tx_tick_q == TICK_LAST) begin
            tx_idx_d   = (tx_idx_q == IDX_LAST) ? '0 : tx_idx_q + IDX_W'(1);
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = (tx_idx_q == IDX_LAST) ? 1'b1 : tx_shift_q[1];
          end
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (baud) tx_tick_d = (tx_tick_q == TICK_LAST) ? '0 : tx_tick_q + TICK_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rx_tick_q    <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_done_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_byte_q  <= '0;
      tx_tick_q    <= '0;
      tx_idx_q     <= '0;
      tx_shift_q   <= '0;
      tx_pend_q    <= 1'b0;
      txd_q        <= 1'b1;
    end else begin
      rxd_meta_q   <= rxd_meta_d;
      rxd_sync_q   <= rxd_sync_d;
      rx_tick_q    <= rx_tick_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_done_q    <= rx_done_d;
      rx_ferr_q    <= rx_ferr_d;
      hold_valid_q <= hold_valid_d;
      hold_byte_q  <= hold_byte_d;
      tx_tick_q    <= tx_tick_d;
      tx_idx_q     <= tx_idx_d;
      tx_shift_q   <= tx_shift_d;
      tx_pend_q    <= tx_pend_d;
      txd_q        <= txd_d;
    end
  end

  assign pins.txd = txd_q;

endmodule

// File: tb/tb_uart.sv
// Directed bench for the uart echo block, run with a shortened baud divider.
module tb_uart;

  localparam int TB_DIV = 8;
  localparam int BIT    = 16 * TB_DIV;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   rx_start_cyc = 0;

  logic [7:0] q_byte[$];
  logic       q_stop[$];
  int         q_width[$];
  int         q_fall[$];

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  uart_if pins ();

  uart #(.DIV_P(TB_DIV)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .pins   (pins)
  );

  // Serial receiver on txd: start width, 8 data bits mid-bit, stop bit
  initial begin : monitor
    int t0, w;
    logic [7:0] d;
    logic s;
    forever begin
      @(negedge sysclk);
      if (pins.txd === 1'b0) begin
        t0 = cyc;
        w  = 0;
        while (pins.txd === 1'b0 && w < 400) begin
          w++;
          @(negedge sysclk);
        end
        repeat (BIT / 2) @(negedge sysclk);
        d[0] = pins.txd;
        for (int i = 1; i < 8; i++) begin
          repeat (BIT) @(negedge sysclk);
          d[i] = pins.txd;
        end
        repeat (BIT) @(negedge sysclk);
        s = pins.txd;
        q_byte.push_back(d);
        q_stop.push_back(s);
        q_width.push_back(w);
        q_fall.push_back(t0);
      end
    end
  end

  initial begin : watchdog
    #(2ms);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic flush_q();
    q_byte.delete();
    q_stop.delete();
    q_width.delete();
    q_fall.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge sysclk);
    pins.rxd = 1'b0;
    rx_start_cyc = cyc;
    repeat (BIT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      pins.rxd = b[i];
      repeat (BIT) @(negedge sysclk);
    end
    pins.rxd = stop_bit;
    repeat (BIT) @(negedge sysclk);
    pins.rxd = 1'b1;
  endtask

  task automatic test_reset();
    int bad_txd, bad_baud, last, n;
    bad_txd  = 0;
    bad_baud = 0;
    pins.rxd = 1'b1;
    reset    = 1'b1;
    repeat (300) begin
      @(negedge sysclk);
      if (pins.txd !== 1'b1) bad_txd++;
      if (dut.u_baud.baud !== 1'b0) bad_baud++;
    end
    checks++;
    if (bad_txd !== 0) begin
      errors++;
      $display("FAIL reset_txd: %0d cycles with txd low, expected 0", bad_txd);
    end
    checks++;
    if (bad_baud !== 0) begin
      errors++;
      $display("FAIL reset_baud: %0d cycles with baud high, expected 0", bad_baud);
    end
    reset = 1'b0;
    last  = -1;
    n     = 0;
    for (int k = 0; k < 6 * TB_DIV && n < 4; k++) begin
      @(negedge sysclk);
      if (dut.u_baud.baud === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== TB_DIV) begin
            errors++;
            $display("FAIL baud_period: got %0d cycles, expected %0d", cyc - last, TB_DIV);
          end
        end
        last = cyc;
        n++;
        k = 0;
      end
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL baud_pulses: got %0d pulses, expected 4", n);
    end
  endtask

  task automatic test_single_frame();
    int k, lat;
    flush_q();
    send_frame(8'hE9, 1'b1);
    k = 0;
    while (q_byte.size() < 1 && k < 12 * BIT) begin
      @(negedge sysclk);
      k++;
    end
    checks++;
    if (q_byte.size() < 1) begin
      errors++;
      $display("FAIL single_timeout: got %0d frames, expected 1", q_byte.size());
      return;
    end
    checks++;
    if (q_byte[0] !== 8'hE9) begin
      errors++;
      $display("FAIL single_byte: got %02h expected e9", q_byte[0]);
    end
    checks++;
    if (q_stop[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_stop: got %b expected 1", q_stop[0]);
    end
    checks++;
    if (q_width[0] < BIT - TB_DIV || q_width[0] > BIT + TB_DIV) begin
      errors++;
      $display("FAIL single_bit_width: got %0d cycles expected %0d +-%0d", q_width[0], BIT, TB_DIV);
    end
    lat = q_fall[0] - rx_start_cyc;
    checks++;
    if (lat < 9 * BIT + BIT / 4 || lat > 9 * BIT + (3 * BIT) / 4) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles expected about %0d", lat, 9 * BIT + BIT / 2);
    end
    repeat (BIT) @(negedge sysclk);
    checks++;
    if (pins.txd !== 1'b1 || q_byte.size() !== 1) begin
      errors++;
      $display("FAIL single_after: txd=%b frames=%0d, expected txd=1 frames=1", pins.txd, q_byte.size());
    end
  endtask

  task automatic test_back_to_back();
    int k;
    flush_q();
    send_frame(8'hE9, 1'b1);
    send_frame(8'hE9, 1'b1);
    k = 0;
    while (q_byte.size() < 2 && k < 14 * BIT) begin
      @(negedge sysclk);
      k++;
    end
    repeat (2 * BIT) @(negedge sysclk);
    checks++;
    if (q_byte.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d frames expected 2", q_byte.size());
      return;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (q_byte[i] !== 8'hE9 || q_stop[i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %02h stop %b expected e9 stop 1", i, q_byte[i], q_stop[i]);
      end
    end
    checks++;
    if (pins.txd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: txd=%b expected 1", pins.txd);
    end
  endtask

  task automatic test_gap_frame();
    int bad, k;
    flush_q();
    bad = 0;
    repeat (20 * BIT) begin
      @(negedge sysclk);
      if (pins.txd !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gap_idle: %0d cycles txd low, expected 0", bad);
    end
    send_frame(8'hE9, 1'b1);
    k = 0;
    while (q_byte.size() < 1 && k < 12 * BIT) begin
      @(negedge sysclk);
      k++;
    end
    repeat (BIT) @(negedge sysclk);
    checks++;
    if (q_byte.size() !== 1 || q_byte[0] !== 8'hE9) begin
      errors++;
      $display("FAIL gap_echo: got %0d frames first %02h expected 1 frame e9",
               q_byte.size(), (q_byte.size() > 0) ? q_byte[0] : 8'h00);
    end
  endtask

  task automatic test_glitch();
    int bad;
    flush_q();
    bad = 0;
    // sub-tick glitch, then a few-tick glitch that is rejected at mid-bit
    @(negedge sysclk);
    pins.rxd = 1'b0;
    repeat (5) @(negedge sysclk);
    pins.rxd = 1'b1;
    repeat (4 * BIT) begin
      @(negedge sysclk);
      if (pins.txd !== 1'b1) bad++;
    end
    pins.rxd = 1'b0;
    repeat (4 * TB_DIV) @(negedge sysclk);
    pins.rxd = 1'b1;
    repeat (14 * BIT) begin
      @(negedge sysclk);
      if (pins.txd !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL glitch_txd: %0d cycles txd low, expected 0", bad);
    end
    checks++;
    if (q_byte.size() !== 0) begin
      errors++;
      $display("FAIL glitch_echo: got %0d frames expected 0", q_byte.size());
    end
  endtask

  task automatic test_framing_error();
    int bad, k;
    flush_q();
    bad = 0;
    send_frame(8'hA5, 1'b0);
    repeat (12 * BIT) begin
      @(negedge sysclk);
      if (pins.txd !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0 || q_byte.size() !== 0) begin
      errors++;
      $display("FAIL ferr_drop: txd low %0d cycles, %0d frames, expected 0 and 0", bad, q_byte.size());
    end
    send_frame(8'h55, 1'b1);
    k = 0;
    while (q_byte.size() < 1 && k < 12 * BIT) begin
      @(negedge sysclk);
      k++;
    end
    repeat (BIT) @(negedge sysclk);
    checks++;
    if (q_byte.size() !== 1 || q_byte[0] !== 8'h55) begin
      errors++;
      $display("FAIL ferr_recover: got %0d frames first %02h expected 1 frame 55",
               q_byte.size(), (q_byte.size() > 0) ? q_byte[0] : 8'h00);
    end
  endtask

  task automatic test_reset_mid_tx();
    int bad, k;
    flush_q();
    send_frame(8'hE9, 1'b1);
    k = 0;
    while (pins.txd !== 1'b0 && k < 4 * BIT) begin
      @(negedge sysclk);
      k++;
    end
    checks++;
    if (pins.txd !== 1'b0) begin
      errors++;
      $display("FAIL rst_tx_start: txd=%b expected 0 within %0d cycles", pins.txd, 4 * BIT);
    end
    repeat (3 * BIT + 20) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    checks++;
    if (pins.txd !== 1'b1) begin
      errors++;
      $display("FAIL rst_tx_txd: got %b expected 1 one edge into reset", pins.txd);
    end
    repeat (10) @(negedge sysclk);
    reset = 1'b0;
    bad = 0;
    repeat (14 * BIT) begin
      @(negedge sysclk);
      if (pins.txd !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rst_tx_residual: %0d cycles txd low after release, expected 0", bad);
    end
    flush_q();
    repeat (2 * BIT) @(negedge sysclk);
    checks++;
    if (q_byte.size() !== 0) begin
      errors++;
      $display("FAIL rst_tx_frames: got %0d frames expected 0", q_byte.size());
    end
  endtask

  initial begin
    pins.rxd = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap_frame();
    test_glitch();
    test_framing_error();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
